// File: rtl/missile_launcher.sv
// Fire-control stage: shot-key decode, frame cooldown, lowest-free slot allocation
// and frame-aligned one-cycle launch pulses; tracks in-flight slots.
module missile_launcher #(
    parameter int                       SHOT_AMOUNT     = 10,
    parameter int                       KEYCODE_WIDTH   = 9,
    parameter logic [KEYCODE_WIDTH-1:0] SHOT_KEY        = KEYCODE_WIDTH'('h070),
    parameter int                       COOLDOWN_FRAMES = 8,
    parameter int                       AUTO_FIRE       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [KEYCODE_WIDTH-1:0] keyCode,
    input  logic                     make,
    input  logic                     brake,
    input  logic                     startOfFrame,
    input  logic [SHOT_AMOUNT-1:0]   missile_done,
    output logic [SHOT_AMOUNT-1:0]   fire,
    output logic [SHOT_AMOUNT-1:0]   active,
    output logic                     dropped,
    output logic                     cooling,
    output logic [15:0]              shots_fired
);

    localparam int             CNT_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, COOLDOWN} state_t;

    state_t                 state_q;
    logic                   key_held_q, key_dly_q, retrig_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SHOT_AMOUNT-1:0] fire_q, active_q;
    logic                   dropped_q, cooling_q;
    logic [15:0]            shots_q;

    logic                   shot_key, key_held_d, press, launch, rearm;
    logic [SHOT_AMOUNT-1:0] free, pick, fire_d;
    logic [CNT_W-1:0]       cnt_d;

    always_comb begin
        shot_key   = (keyCode == SHOT_KEY);
        key_held_d = key_held_q;
        if (make && shot_key)  key_held_d = 1'b1;
        if (brake && shot_key) key_held_d = 1'b0;
        press  = key_held_q & ~key_dly_q;
        free   = ~active_q;
        // two's-complement trick isolates the lowest set bit of the free mask
        pick   = free & (~free + SHOT_AMOUNT'(1));
        launch = (state_q == WAIT_FRAME) && startOfFrame && (|free);
        fire_d = launch ? pick : '0;
        cnt_d  = cnt_q - CNT_W'(1);
        // a press landing on the exit frame still counts as a retrigger
        rearm  = retrig_q | press | ((AUTO_FIRE != 0) && key_held_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            key_held_q <= 1'b0;
            key_dly_q  <= 1'b0;
            retrig_q   <= 1'b0;
            cnt_q      <= '0;
            fire_q     <= '0;
            active_q   <= '0;
            dropped_q  <= 1'b0;
            cooling_q  <= 1'b0;
            shots_q    <= '0;
        end else begin
            key_held_q <= key_held_d;
            key_dly_q  <= key_held_q;
            fire_q     <= fire_d;
            active_q   <= (active_q & ~missile_done) | fire_d;
            dropped_q  <= 1'b0;
            if (launch) shots_q <= shots_q + 16'd1;

            case (state_q)
                IDLE: begin
                    if (press) state_q <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (startOfFrame) begin
                        if (|free) begin
                            cnt_q <= CNT_LOAD;
                            if (COOLDOWN_FRAMES == 0) begin
                                state_q <= ((AUTO_FIRE != 0) && key_held_q) ? WAIT_FRAME : IDLE;
                            end else begin
                                state_q   <= COOLDOWN;
                                cooling_q <= 1'b1;
                            end
                        end else begin
                            dropped_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                COOLDOWN: begin
                    if (press) retrig_q <= 1'b1;
                    if (startOfFrame) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == '0) begin
                            cooling_q <= 1'b0;
                            retrig_q  <= 1'b0;
                            state_q   <= rearm ? WAIT_FRAME : IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fire        = fire_q;
    assign active      = active_q;
    assign dropped     = dropped_q;
    assign cooling     = cooling_q;
    assign shots_fired = shots_q;

endmodule

// File: tb/tb_missile_launcher.sv
// Bench for missile_launcher: vector table plus hand sequences; u0 is single-shot,
// u1 runs with AUTO_FIRE, both share stimulus.
module tb_missile_launcher;

    localparam int N = 10;
    localparam logic [8:0] KEY = 9'h070;

    logic         clk = 1'b0;
    logic         reset, make, brake, sof;
    logic [8:0]   keyCode;
    logic [N-1:0] missile_done;

    logic [N-1:0] fire0, active0, fire1, active1;
    logic         dropped0, cooling0, dropped1, cooling1;
    logic [15:0]  shots0, shots1;

    always #5 clk = ~clk;

    missile_launcher #(.SHOT_AMOUNT(N), .KEYCODE_WIDTH(9), .SHOT_KEY(KEY),
                       .COOLDOWN_FRAMES(8), .AUTO_FIRE(0)) u0 (
        .clk(clk), .reset(reset), .keyCode(keyCode), .make(make), .brake(brake),
        .startOfFrame(sof), .missile_done(missile_done), .fire(fire0), .active(active0),
        .dropped(dropped0), .cooling(cooling0), .shots_fired(shots0));

    missile_launcher #(.SHOT_AMOUNT(N), .KEYCODE_WIDTH(9), .SHOT_KEY(KEY),
                       .COOLDOWN_FRAMES(8), .AUTO_FIRE(1)) u1 (
        .clk(clk), .reset(reset), .keyCode(keyCode), .make(make), .brake(brake),
        .startOfFrame(sof), .missile_done(missile_done), .fire(fire1), .active(active1),
        .dropped(dropped1), .cooling(cooling1), .shots_fired(shots1));

    typedef struct packed {
        logic rst, mk, bk; logic [8:0] kc; logic sof; logic [N-1:0] done;
    } stim_t;
    typedef struct packed {
        logic [N-1:0] fire, active; logic dropped, cooling; logic [15:0] shots;
    } exp_t;
    typedef struct packed { stim_t s; exp_t e; } vec_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    int    total = 0, bad = 0;
    logic [N-1:0] ea;
    logic [15:0]  es;
    stim_t S_RST, S_IDLE, S_MAKE, S_BRK, S_SOF;

    function automatic stim_t st(logic rst, logic mk, logic bk, logic [8:0] kc,
                                 logic f, logic [N-1:0] done);
        stim_t s;
        s.rst = rst; s.mk = mk; s.bk = bk; s.kc = kc; s.sof = f; s.done = done;
        return s;
    endfunction

    function automatic void add(stim_t s, logic [N-1:0] f, logic [N-1:0] a,
                                logic d, logic c, logic [15:0] n);
        vec_t v;
        v.s = s; v.e.fire = f; v.e.active = a; v.e.dropped = d; v.e.cooling = c; v.e.shots = n;
        tbl.push_back(v);
    endfunction

    // drive one cycle, queue the expectation, compare once the edge has produced outputs
    task automatic run(input stim_t s, input exp_t e, input bit sel, input string nm);
        exp_t got, want;
        reset = s.rst; make = s.mk; brake = s.bk; keyCode = s.kc; sof = s.sof;
        missile_done = s.done;
        sb.push_back(e);
        @(posedge clk); #1;
        got  = sel ? {fire1, active1, dropped1, cooling1, shots1}
                   : {fire0, active0, dropped0, cooling0, shots0};
        want = sb.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got fire=%b active=%b dropped=%b cooling=%b shots=%0d, want fire=%b active=%b dropped=%b cooling=%b shots=%0d",
                     nm, got.fire, got.active, got.dropped, got.cooling, got.shots,
                     want.fire, want.active, want.dropped, want.cooling, want.shots);
        end
    endtask

    // hand sequences: active mask and shot count tracked here, fire/dropped/cooling given
    task automatic hs(input stim_t s, input logic [N-1:0] f, input logic d, input logic c,
                      input bit sel, input string nm);
        exp_t e;
        if (s.rst) begin
            ea = '0; es = '0;
        end else begin
            ea = (ea & ~s.done) | f;
            if (|f) es = es + 16'd1;
        end
        e.fire = f; e.active = ea; e.dropped = d; e.cooling = c; e.shots = es;
        run(s, e, sel, nm);
    endtask

    task automatic cool_out(input bit sel, input string nm);
        for (int i = 0; i < 7; i++) hs(S_SOF, '0, 1'b0, 1'b1, sel, nm);
        hs(S_SOF, '0, 1'b0, 1'b0, sel, {nm, "_exit"});
    endtask

    task automatic launch_one(input int k, input string nm);
        hs(S_MAKE, '0, 1'b0, 1'b0, 0, {nm, "_make"});
        hs(S_IDLE, '0, 1'b0, 1'b0, 0, {nm, "_arm"});
        hs(S_SOF, N'(1) << k, 1'b0, 1'b1, 0, {nm, "_fire"});
        hs(S_BRK, '0, 1'b0, 1'b1, 0, {nm, "_brk"});
        cool_out(0, {nm, "_cool"});
    endtask

    initial begin
        S_RST  = st(1, 0, 0, 9'h0, 0, '0);
        S_IDLE = st(0, 0, 0, 9'h0, 0, '0);
        S_MAKE = st(0, 1, 0, KEY,  0, '0);
        S_BRK  = st(0, 0, 1, KEY,  0, '0);
        S_SOF  = st(0, 0, 0, 9'h0, 1, '0);
        ea = '0; es = '0;
        reset = 1'b1; make = 1'b0; brake = 1'b0; keyCode = '0; sof = 1'b0; missile_done = '0;

        // single-shot launch, cooldown, press+frame coincidence, done handling, key decode
        add(S_RST,  0, 0, 0, 0, 0);
        add(S_MAKE, 0, 0, 0, 0, 0);
        add(S_IDLE, 0, 0, 0, 0, 0);
        add(S_SOF,  1, 1, 0, 1, 1);
        add(S_IDLE, 0, 1, 0, 1, 1);
        add(S_BRK,  0, 1, 0, 1, 1);
        for (int i = 0; i < 7; i++) add(S_SOF, 0, 1, 0, 1, 1);
        add(S_SOF,  0, 1, 0, 0, 1);
        add(S_SOF,  0, 1, 0, 0, 1);
        add(S_MAKE, 0, 1, 0, 0, 1);
        add(S_SOF,  0, 1, 0, 0, 1);
        add(S_SOF,  2, 3, 0, 1, 2);
        add(S_BRK,  0, 3, 0, 1, 2);
        add(st(0, 0, 0, 9'h0, 0, 10'b1), 0, 2, 0, 1, 2);
        add(st(0, 0, 0, 9'h0, 0, 10'b1), 0, 2, 0, 1, 2);
        for (int i = 0; i < 7; i++) add(S_SOF, 0, 2, 0, 1, 2);
        add(S_SOF,  0, 2, 0, 0, 2);
        add(st(0, 1, 1, KEY, 0, '0), 0, 2, 0, 0, 2);
        add(S_IDLE, 0, 2, 0, 0, 2);
        add(S_SOF,  0, 2, 0, 0, 2);
        add(st(0, 1, 0, 9'h071, 0, '0), 0, 2, 0, 0, 2);
        add(S_IDLE, 0, 2, 0, 0, 2);
        add(S_SOF,  0, 2, 0, 0, 2);
        for (int i = 0; i < tbl.size(); i++) run(tbl[i].s, tbl[i].e, 0, $sformatf("tbl%0d", i));

        // fill every slot, then drop, then reuse a freed slot
        hs(S_RST, '0, 1'b0, 1'b0, 0, "fill_rst");
        for (int k = 0; k < N; k++) launch_one(k, $sformatf("fill%0d", k));
        hs(S_MAKE, '0, 1'b0, 1'b0, 0, "full_make");
        hs(S_IDLE, '0, 1'b0, 1'b0, 0, "full_arm");
        hs(S_SOF,  '0, 1'b1, 1'b0, 0, "full_drop");
        hs(S_BRK,  '0, 1'b0, 1'b0, 0, "full_brk");
        hs(S_SOF,  '0, 1'b0, 1'b0, 0, "full_idle");
        hs(st(0, 0, 0, 9'h0, 0, 10'b0000001000), '0, 1'b0, 1'b0, 0, "free3");
        launch_one(3, "reuse3");

        // two presses during cooldown give exactly one extra launch
        hs(S_RST,  '0, 1'b0, 1'b0, 0, "rt_rst");
        hs(S_MAKE, '0, 1'b0, 1'b0, 0, "rt_make");
        hs(S_IDLE, '0, 1'b0, 1'b0, 0, "rt_arm");
        hs(S_SOF,  10'b1, 1'b0, 1'b1, 0, "rt_fire0");
        hs(S_BRK,  '0, 1'b0, 1'b1, 0, "rt_brk");
        for (int i = 0; i < 2; i++) begin
            hs(S_MAKE, '0, 1'b0, 1'b1, 0, "rt_pmake");
            hs(S_IDLE, '0, 1'b0, 1'b1, 0, "rt_press");
            hs(S_BRK,  '0, 1'b0, 1'b1, 0, "rt_pbrk");
        end
        cool_out(0, "rt_cd1");
        hs(S_SOF, 10'b10, 1'b0, 1'b1, 0, "rt_fire1");
        cool_out(0, "rt_cd2");
        hs(S_SOF, '0, 1'b0, 1'b0, 0, "rt_noextra");
        hs(S_SOF, '0, 1'b0, 1'b0, 0, "rt_noextra2");

        // reset mid-flight with 4 slots active and 5 frames of cooldown left
        hs(S_RST, '0, 1'b0, 1'b0, 0, "mr_rst");
        for (int k = 0; k < 3; k++) launch_one(k, $sformatf("mr%0d", k));
        hs(S_MAKE, '0, 1'b0, 1'b0, 0, "mr3_make");
        hs(S_IDLE, '0, 1'b0, 1'b0, 0, "mr3_arm");
        hs(S_SOF,  10'b1000, 1'b0, 1'b1, 0, "mr3_fire");
        hs(S_BRK,  '0, 1'b0, 1'b1, 0, "mr3_brk");
        for (int i = 0; i < 3; i++) hs(S_SOF, '0, 1'b0, 1'b1, 0, "mr_cd");
        hs(S_RST,  '0, 1'b0, 1'b0, 0, "mr_reset");
        hs(S_IDLE, '0, 1'b0, 1'b0, 0, "mr_after");
        hs(S_SOF,  '0, 1'b0, 1'b0, 0, "mr_nopending");

        // auto-fire while held: launches on frames 1, 10, 19 into slots 0, 1, 2
        hs(S_RST,  '0, 1'b0, 1'b0, 1, "af_rst");
        hs(S_MAKE, '0, 1'b0, 1'b0, 1, "af_make");
        hs(S_IDLE, '0, 1'b0, 1'b0, 1, "af_arm");
        for (int i = 1; i <= 19; i++) begin
            int j;
            logic [N-1:0] f;
            j = (i - 1) % 9;
            f = (j == 0) ? (N'(1) << ((i - 1) / 9)) : '0;
            hs(S_SOF, f, 1'b0, (j != 8), 1, $sformatf("af_frame%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
